// File: rtl/program_loader.sv
// Program loader: takes a valid/ready byte stream, writes it to consecutive register_file
// addresses and raises op to hand the memory to the controller. Optional macro: PROG_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wr,
    output logic                  op,
    output logic                  done,
    output logic                  overflow,
    output logic                  csum_err,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int unsigned           CW         = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, RUN} state_t;

    state_t                state, state_next;
    logic                  last_q, last_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CW-1:0]         count_next;
    logic                  ovf_next;
    logic                  fire;

`ifdef PROG_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_next;
    logic                  csum_err_next;
`endif

    assign fire = in_valid && in_ready;

    // Next-state and session bookkeeping
    always_comb begin
        state_next = state;
        addr_next  = mem_address;
        data_next  = mem_data;
        last_next  = last_q;
        count_next = word_count;
        ovf_next   = overflow;
`ifdef PROG_CHECKSUM_EN
        sum_next      = sum_q;
        csum_err_next = csum_err;
`endif
        case (state)
            IDLE, RUN: begin
                if (start) begin
                    state_next = RECV;
                    addr_next  = FIRST_ADDR;
                    count_next = '0;
                    ovf_next   = 1'b0;
`ifdef PROG_CHECKSUM_EN
                    sum_next      = '0;
                    csum_err_next = 1'b0;
`endif
                end
            end
            RECV: begin
                if (fire) begin
`ifdef PROG_CHECKSUM_EN
                    // The flagged byte is the checksum and never reaches memory
                    if (in_last) begin
                        if (sum_q == in_data) begin
                            state_next = RUN;
                        end else begin
                            csum_err_next = 1'b1;
                            state_next    = IDLE;
                        end
                    end else begin
                        sum_next   = sum_q + in_data;
                        data_next  = in_data;
                        last_next  = 1'b0;
                        state_next = WRITE;
                    end
`else
                    data_next  = in_data;
                    last_next  = in_last;
                    state_next = WRITE;
`endif
                end
            end
            WRITE: begin
                addr_next  = mem_address + ADDR_WIDTH'(1);
                count_next = word_count + CW'(1);
                if (last_q) begin
                    state_next = RUN;
                end else if (mem_address == LAST_ADDR) begin
                    ovf_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RECV;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; strobes are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_address <= FIRST_ADDR;
            mem_data    <= '0;
            last_q      <= 1'b0;
            word_count  <= '0;
            overflow    <= 1'b0;
            in_ready    <= 1'b0;
            mem_wr      <= 1'b0;
            op          <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            mem_address <= addr_next;
            mem_data    <= data_next;
            last_q      <= last_next;
            word_count  <= count_next;
            overflow    <= ovf_next;
            in_ready    <= (state_next == RECV);
            mem_wr      <= (state_next == WRITE);
            op          <= (state_next == RUN);
            done        <= (state_next == RUN) && (state != RUN);
        end
    end

`ifdef PROG_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q    <= '0;
            csum_err <= 1'b0;
        end else begin
            sum_q    <= sum_next;
            csum_err <= csum_err_next;
        end
    end
`else
    assign csum_err = 1'b0;
`endif

endmodule
